// File: rtl/rgb_pattern_gen.sv
// rgb_pattern_gen: panel bring-up test-pattern source placed behind the display
// timing generator. Tracks the active x/y position from the {vsync,hsync,den}
// bundle and emits a 24-bit RGB pixel aligned with a 2-cycle delayed sync copy.
// Optional feature macro: PATTERN_AUTOCYCLE_EN (adds auto_en; the active pattern
// then steps every AUTO_FRAMES frames instead of following pat_sel).
module rgb_pattern_gen #(
    parameter int BAR_COUNT  = 8,
    parameter int CHECK_LOG2 = 5
`ifdef PATTERN_AUTOCYCLE_EN
    ,
    parameter int AUTO_FRAMES = 64
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  sync_in,
    input  logic [11:0] h_size,
    input  logic [10:0] v_size,
    input  logic [2:0]  pat_sel,
    input  logic [23:0] solid_rgb,
`ifdef PATTERN_AUTOCYCLE_EN
    input  logic        auto_en,
`endif
    output logic [23:0] rgb_out,
    output logic [2:0]  sync_out,
    output logic [7:0]  frame_cnt
);

    // Palette has exactly eight entries; the last bar index absorbs remainder pixels.
    localparam logic [2:0] BAR_LAST = 3'(BAR_COUNT - 1);

    logic [2:0]  r_s1;
    logic        r_vs_prev;
    logic        r_den_prev;
    logic [11:0] r_x;
    logic [10:0] r_y;
    logic        r_y_arm;
    logic [8:0]  r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic [2:0]  r_pat;
    logic [23:0] r_solid;
    logic [7:0]  r_frame_cnt;
    logic [23:0] r_rgb;
    logic [2:0]  r_sync;

    logic        w_den;
    logic        w_vs_rise;
    logic        w_den_fall;
    logic [8:0]  w_bar_w;
    logic [11:0] w_h_last;
    logic [10:0] w_v_last;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_color;
    logic        w_check;
    logic        w_grid;

    assign w_den      = r_s1[0];
    assign w_vs_rise  = r_s1[2] & ~r_vs_prev;
    assign w_den_fall = ~r_s1[0] & r_den_prev;
    assign w_bar_w    = (h_size[11:3] == 9'd0) ? 9'd1 : h_size[11:3];
    assign w_h_last   = h_size - 12'd1;
    assign w_v_last   = v_size - 11'd1;

    // Stage 1: register the sync bundle and keep the previous sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 3'd0;
            r_vs_prev  <= 1'b0;
            r_den_prev <= 1'b0;
        end else begin
            r_s1       <= sync_in;
            r_vs_prev  <= r_s1[2];
            r_den_prev <= r_s1[0];
        end
    end

    // Position counters; y is held at 0 after reset until a vsync rise re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= 12'd0;
            r_y     <= 11'd0;
            r_y_arm <= 1'b0;
        end else begin
            if (w_den) begin
                r_x <= (r_x == 12'hFFF) ? r_x : r_x + 12'd1;
            end else begin
                r_x <= 12'd0;
            end
            if (w_vs_rise) begin
                r_y     <= 11'd0;
                r_y_arm <= 1'b1;
            end else if (w_den_fall && r_y_arm && (r_y != 11'h7FF)) begin
                r_y <= r_y + 11'd1;
            end
        end
    end

    // Colour-bar position: counter wraps every bar_w pixels and steps the saturating index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_cnt <= 9'd0;
            r_bar_idx <= 3'd0;
        end else if (!w_den) begin
            r_bar_cnt <= 9'd0;
            r_bar_idx <= 3'd0;
        end else if (r_bar_cnt == (w_bar_w - 9'd1)) begin
            r_bar_cnt <= 9'd0;
            r_bar_idx <= (r_bar_idx == BAR_LAST) ? r_bar_idx : r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 9'd1;
        end
    end

`ifdef PATTERN_AUTOCYCLE_EN
    localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

    logic [AW-1:0] r_auto_cnt;
    logic          w_auto_step;

    assign w_auto_step = (r_auto_cnt == AUTO_LAST);

    // Auto-cycle frame counter; idle and cleared while auto_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (!auto_en) begin
            r_auto_cnt <= '0;
        end else if (w_vs_rise) begin
            r_auto_cnt <= w_auto_step ? '0 : r_auto_cnt + 1'b1;
        end
    end
`endif

    // Frame boundary: count frames and shadow the pattern controls so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
            r_solid     <= 24'd0;
            r_pat       <= 3'd0;
        end else if (w_vs_rise) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_solid     <= solid_rgb;
`ifdef PATTERN_AUTOCYCLE_EN
            if (auto_en) begin
                if (w_auto_step) begin
                    r_pat <= r_pat + 3'd1;
                end
            end else begin
                r_pat <= pat_sel;
            end
`else
            r_pat <= pat_sel;
`endif
        end
    end

    // Bar palette lookup.
    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // Pattern colour for the pixel currently in stage 1.
    always_comb begin
        w_check = r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2];
        w_grid  = (r_x == 12'd0) || (r_x == w_h_last) ||
                  (r_y == 11'd0) || (r_y == w_v_last) ||
                  (r_x[CHECK_LOG2-1:0] == '0) || (r_y[CHECK_LOG2-1:0] == '0);
        w_color = 24'h000000;
        case (r_pat)
            3'd0:    w_color = r_solid;
            3'd1:    w_color = w_bar_rgb;
            3'd2:    w_color = {3{r_x[7:0]}};
            3'd3:    w_color = {3{r_y[7:0]}};
            3'd4:    w_color = w_check ? 24'hFFFFFF : 24'h000000;
            3'd5:    w_color = w_grid ? 24'hFFFFFF : 24'h000000;
            3'd6:    w_color = {r_x[7:0], r_y[7:0], r_frame_cnt};
            default: w_color = 24'h000000;
        endcase
    end

    // Stage 2: output pixel and delayed sync; pixel data is blanked outside den.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb  <= 24'd0;
            r_sync <= 3'd0;
        end else begin
            r_sync <= r_s1;
            r_rgb  <= w_den ? w_color : 24'd0;
        end
    end

    assign rgb_out   = r_rgb;
    assign sync_out  = r_sync;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Testbench for rgb_pattern_gen: the driver pushes the expected colour of every
// active pixel into a scoreboard queue; a negedge monitor pops and compares
// whenever the DUT presents den on sync_out, and checks sync_out against the
// bench's own 2-deep history of driven sync values.
module tb_rgb_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sync_in;
    logic [11:0] h_size;
    logic [10:0] v_size;
    logic [2:0]  pat_sel;
    logic [23:0] solid_rgb;
    logic [23:0] rgb_out;
    logic [2:0]  sync_out;
    logic [7:0]  frame_cnt;

    rgb_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (sync_in),
        .h_size    (h_size),
        .v_size    (v_size),
        .pat_sel   (pat_sel),
        .solid_rgb (solid_rgb),
        .rgb_out   (rgb_out),
        .sync_out  (sync_out),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_fc = 0;
    bit          mon_en = 1'b0;
    logic [2:0]  h0 = 3'd0, h1 = 3'd0, h2 = 3'd0;
    logic [23:0] sb_q[$];

    function automatic logic [23:0] exp_color(input int pat, input int x, input int y,
                                              input int hs, input int vs, input int fc,
                                              input logic [23:0] solid);
        int bw;
        int idx;
        logic [7:0] g;
        exp_color = 24'h000000;
        case (pat)
            0: exp_color = solid;
            1: begin
                bw = hs / 8;
                if (bw == 0) bw = 1;
                idx = x / bw;
                if (idx > 7) idx = 7;
                case (idx)
                    0: exp_color = 24'hFFFFFF;
                    1: exp_color = 24'hFFFF00;
                    2: exp_color = 24'h00FFFF;
                    3: exp_color = 24'h00FF00;
                    4: exp_color = 24'hFF00FF;
                    5: exp_color = 24'hFF0000;
                    6: exp_color = 24'h0000FF;
                    default: exp_color = 24'h000000;
                endcase
            end
            2: begin g = 8'(x % 256); exp_color = {g, g, g}; end
            3: begin g = 8'(y % 256); exp_color = {g, g, g}; end
            4: exp_color = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            5: exp_color = (x == 0 || x == hs - 1 || y == 0 || y == vs - 1 ||
                            x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h000000;
            6: exp_color = {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
            default: exp_color = 24'h000000;
        endcase
    endfunction

    // Monitor: sync delay check every cycle, pixel check against the scoreboard on den.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (sync_out !== h2) begin
                n_bad++;
                $display("FAIL sync_out: got %b expected %b at %0t", sync_out, h2, $time);
            end
            if (sync_out[0] === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pixel_unexpected: got %h expected no pixel at %0t", rgb_out, $time);
                end else begin
                    logic [23:0] e;
                    e = sb_q.pop_front();
                    if (rgb_out !== e) begin
                        n_bad++;
                        $display("FAIL rgb_out: got %h expected %h at %0t", rgb_out, e, $time);
                    end
                end
            end else begin
                n_cmp++;
                if (rgb_out !== 24'h000000) begin
                    n_bad++;
                    $display("FAIL rgb_blank: got %h expected 000000 at %0t", rgb_out, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [2:0] s, input bit has_pix, input logic [23:0] e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        h2 = h1;
        h1 = h0;
        h0 = s;
        sync_in = s;
        if (has_pix) sb_q.push_back(e);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            h0 = 3'd0;
            h1 = 3'd0;
            h2 = 3'd0;
            sb_q.delete();
            sync_in = 3'b001;
            if (i == 0) begin
                #2;
                check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
                check("rst_rgb_out", 32'(rgb_out), 32'd0);
                check("rst_sync_out", 32'(sync_out), 32'd0);
            end
        end
    endtask

    task automatic run_frame(input int hs, input int vs, input bit chg,
                             input logic [2:0] new_pat, input logic [23:0] new_solid,
                             input int rst_line, input int rst_px);
        int lp;
        logic [23:0] ls;
        h_size = 12'(hs);
        v_size = 11'(vs);
        lp = int'(pat_sel);
        ls = solid_rgb;
        exp_fc = (exp_fc + 1) % 256;
        step(3'b100, 1'b0, 24'd0);
        step(3'b100, 1'b0, 24'd0);
        step(3'b000, 1'b0, 24'd0);
        for (int ln = 0; ln < vs; ln++) begin
            if (chg && ln == 1) begin
                pat_sel = new_pat;
                solid_rgb = new_solid;
            end
            step(3'b010, 1'b0, 24'd0);
            step(3'b010, 1'b0, 24'd0);
            step(3'b000, 1'b0, 24'd0);
            step(3'b000, 1'b0, 24'd0);
            for (int px = 0; px < hs; px++) begin
                if (ln == rst_line && px == rst_px) begin
                    do_reset();
                    lp = 0;
                    ls = 24'd0;
                    exp_fc = 0;
                end
                step(3'b001, 1'b1, exp_color(lp, px, ln, hs, vs, exp_fc, ls));
            end
            step(3'b000, 1'b0, 24'd0);
            step(3'b000, 1'b0, 24'd0);
        end
        step(3'b000, 1'b0, 24'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    endtask

    initial begin
        rst_n = 1'b0;
        sync_in = 3'd0;
        h_size = 12'd16;
        v_size = 11'd4;
        pat_sel = 3'd1;
        solid_rgb = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check("init_rgb_out", 32'(rgb_out), 32'd0);
        check("init_sync_out", 32'(sync_out), 32'd0);
        check("init_frame_cnt", 32'(frame_cnt), 32'd0);
        mon_en = 1'b1;
        repeat (2) step(3'b000, 1'b0, 24'd0);

        // Colour bars: 2 px per bar, remainder pixels on bar 7, and bar_w forced to 1.
        pat_sel = 3'd1;
        run_frame(16, 4, 1'b0, 3'd0, 24'd0, -1, -1);
        run_frame(20, 2, 1'b0, 3'd0, 24'd0, -1, -1);
        run_frame(4, 2, 1'b0, 3'd0, 24'd0, -1, -1);

        // Solid colour change mid-frame only takes effect at the next frame.
        pat_sel = 3'd0;
        solid_rgb = 24'h123456;
        run_frame(16, 4, 1'b1, 3'd0, 24'hABCDEF, -1, -1);
        run_frame(16, 4, 1'b0, 3'd0, 24'd0, -1, -1);

        // Ramps, checkerboard, grid and black.
        pat_sel = 3'd2;
        run_frame(300, 2, 1'b0, 3'd0, 24'd0, -1, -1);
        pat_sel = 3'd3;
        run_frame(8, 6, 1'b0, 3'd0, 24'd0, -1, -1);
        pat_sel = 3'd4;
        run_frame(70, 40, 1'b0, 3'd0, 24'd0, -1, -1);
        pat_sel = 3'd5;
        run_frame(70, 40, 1'b0, 3'd0, 24'd0, -1, -1);
        pat_sel = 3'd7;
        run_frame(8, 2, 1'b0, 3'd0, 24'd0, -1, -1);

        // Position/frame-count pattern across a frame_cnt wrap.
        pat_sel = 3'd6;
        for (int f = 0; f < 258; f++) begin
            run_frame(4, 2, 1'b0, 3'd0, 24'd0, -1, -1);
        end

        // Reset mid-line: remainder of the frame is solid black, next frame uses pat_sel.
        pat_sel = 3'd2;
        solid_rgb = 24'h55AA55;
        run_frame(16, 3, 1'b0, 3'd0, 24'd0, 1, 5);
        run_frame(16, 3, 1'b0, 3'd0, 24'd0, -1, -1);

        repeat (4) step(3'b000, 1'b0, 24'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
